// File: rtl/crossbar_rr_nxm_pkg.sv
// ---------------------------------------------------------------------------
// crossbar_rr_nxm_pkg
//   Shared definitions for the round-robin crossbar family: default sizing
//   and helpers that compute index widths and lane offsets into the
//   flattened per-port buses. Intended to be reused by later crossbar
//   variants, so nothing here is specific to one instance size.
// ---------------------------------------------------------------------------
package crossbar_rr_nxm_pkg;

    localparam int unsigned XBAR_DEF_WIDTH = 8;
    localparam int unsigned XBAR_DEF_N_SRC = 4;
    localparam int unsigned XBAR_DEF_N_DST = 4;

    // Width of an index able to address n entries (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of lane 'lane' in a flattened bus of 'w'-bit lanes.
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/crossbar_rr_nxm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter for one crossbar destination. The search for a
//   winner starts at the internal pointer; the pointer moves to one past the
//   winner only when the caller reports that the grant was taken.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (pointer -> 0)
//   req        request vector, one bit per source
//   advance    grant was accepted this cycle; move the pointer
//   grant      one-hot grant (all zero when no request)
//   grant_idx  binary index of the granted source
// ---------------------------------------------------------------------------
module rr_arbiter
    import crossbar_rr_nxm_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Walk the sources starting at ptr_q, wrapping at N; first requester
    // wins. One extra bit in the sum keeps the wrap test exact.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/crossbar_rr_nxm.sv
// ---------------------------------------------------------------------------
// crossbar_rr_nxm
//   N_SRC x N_DST valid/ready crossbar. Every destination owns a one-entry
//   registered output slot and a round-robin arbiter, so all destinations
//   run in parallel and no source can be starved. Each output beat carries
//   the index of the source that sent it.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   s_val        per-source valid
//   s_dst        per-source destination index, lane i at [i*DST_W +: DST_W]
//   s_data       per-source payload, lane i at [i*WIDTH +: WIDTH]
//   s_rdy        per-source ready (combinational)
//   m_val        per-destination valid (registered)
//   m_src        source index of the held beat (registered)
//   m_data       held payload (registered)
//   m_rdy        per-destination ready
//   dst_err      sticky: a valid source presented an out-of-range destination
// ---------------------------------------------------------------------------
module crossbar_rr_nxm
    import crossbar_rr_nxm_pkg::*;
#(
    parameter  int unsigned WIDTH = XBAR_DEF_WIDTH,
    parameter  int unsigned N_SRC = XBAR_DEF_N_SRC,
    parameter  int unsigned N_DST = XBAR_DEF_N_DST,
    localparam int unsigned DST_W = idx_w(N_DST),
    localparam int unsigned SRC_W = idx_w(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       s_val,
    input  logic [N_SRC*DST_W-1:0] s_dst,
    input  logic [N_SRC*WIDTH-1:0] s_data,
    output logic [N_SRC-1:0]       s_rdy,
    output logic [N_DST-1:0]       m_val,
    output logic [N_DST*SRC_W-1:0] m_src,
    output logic [N_DST*WIDTH-1:0] m_data,
    input  logic [N_DST-1:0]       m_rdy,
    output logic                   dst_err
);

    localparam logic [DST_W:0] N_DST_EXT = (DST_W+1)'(N_DST);

    logic [DST_W-1:0] dst_a  [N_SRC];
    logic [N_SRC-1:0] in_rng;
    logic [N_SRC-1:0] oor;
    logic [N_SRC-1:0] req    [N_DST];
    logic [N_SRC-1:0] grant  [N_DST];
    logic [SRC_W-1:0] gidx   [N_DST];
    logic [N_DST-1:0] can_take;
    logic [N_DST-1:0] take;
    logic             dst_err_q;
    logic             dst_err_d;

    // Decode each source's destination; a destination index beyond N_DST
    // (only possible when N_DST is not a power of two) never requests.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            dst_a[i]  = s_dst[lane_lo(i, DST_W) +: DST_W];
            in_rng[i] = ({1'b0, dst_a[i]} < N_DST_EXT);
            oor[i]    = s_val[i] & ~in_rng[i];
        end
    end

    always_comb begin
        for (int j = 0; j < N_DST; j++) begin
            for (int i = 0; i < N_SRC; i++) begin
                req[j][i] = s_val[i] & (dst_a[i] == DST_W'(j)) & in_rng[i];
            end
        end
    end

    // A source targets one destination, so at most one term per source is
    // set. Gating with rst_n keeps ready low for the whole reset window.
    always_comb begin
        s_rdy = '0;
        for (int j = 0; j < N_DST; j++) begin
            s_rdy = s_rdy | (grant[j] & {N_SRC{can_take[j]}});
        end
        s_rdy = s_rdy & {N_SRC{rst_n}};
    end

    assign dst_err_d = dst_err_q | (|oor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_err_q <= 1'b0;
        end else begin
            dst_err_q <= dst_err_d;
        end
    end

    assign dst_err = dst_err_q;

    for (genvar j = 0; j < N_DST; j++) begin : g_dst
        logic             val_q;
        logic             val_d;
        logic [SRC_W-1:0] src_q;
        logic [SRC_W-1:0] src_d;
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;

        // Pass-through drain: a full slot can refill on the same edge it
        // is emptied, so a streaming destination never bubbles.
        assign can_take[j] = ~val_q | m_rdy[j];
        assign take[j]     = (|grant[j]) & can_take[j];

        rr_arbiter #(
            .N (N_SRC)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req[j]),
            .advance   (take[j]),
            .grant     (grant[j]),
            .grant_idx (gidx[j])
        );

        always_comb begin
            val_d  = val_q;
            src_d  = src_q;
            data_d = data_q;
            if (take[j]) begin
                val_d  = 1'b1;
                src_d  = gidx[j];
                data_d = s_data[lane_lo(32'(gidx[j]), WIDTH) +: WIDTH];
            end else if (m_rdy[j]) begin
                val_d  = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val_q  <= 1'b0;
                src_q  <= '0;
                data_q <= '0;
            end else begin
                val_q  <= val_d;
                src_q  <= src_d;
                data_q <= data_d;
            end
        end

        assign m_val[j]                          = val_q;
        assign m_src[lane_lo(j, SRC_W) +: SRC_W]  = src_q;
        assign m_data[lane_lo(j, WIDTH) +: WIDTH] = data_q;
    end

endmodule

// File: tb/tb_crossbar_rr_nxm.sv
// ---------------------------------------------------------------------------
// tb_crossbar_rr_nxm
//   Bench for crossbar_rr_nxm: a 4x4 instance driven by directed and
//   random traffic and checked every cycle against a behavioural model,
//   plus a 4x3 instance for the out-of-range destination case.
// ---------------------------------------------------------------------------
module tb_crossbar_rr_nxm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [3:0]  s_val;
    logic [7:0]  s_dst;
    logic [31:0] s_data;
    logic [3:0]  s_rdy;
    logic [3:0]  m_val;
    logic [7:0]  m_src;
    logic [31:0] m_data;
    logic [3:0]  m_rdy;
    logic        dst_err;

    logic [3:0]  s_val3;
    logic [7:0]  s_dst3;
    logic [31:0] s_data3;
    logic [3:0]  s_rdy3;
    logic [2:0]  m_val3;
    logic [5:0]  m_src3;
    logic [23:0] m_data3;
    logic [2:0]  m_rdy3;
    logic        dst_err3;

    crossbar_rr_nxm #(.WIDTH(8), .N_SRC(4), .N_DST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_val(s_val), .s_dst(s_dst), .s_data(s_data), .s_rdy(s_rdy),
        .m_val(m_val), .m_src(m_src), .m_data(m_data), .m_rdy(m_rdy),
        .dst_err(dst_err)
    );

    crossbar_rr_nxm #(.WIDTH(8), .N_SRC(4), .N_DST(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_val(s_val3), .s_dst(s_dst3), .s_data(s_data3), .s_rdy(s_rdy3),
        .m_val(m_val3), .m_src(m_src3), .m_data(m_data3), .m_rdy(m_rdy3),
        .dst_err(dst_err3)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model of the 4x4 instance: the beat held by each
    // destination and the source it served last.
    int mdl_val  [4];
    int mdl_src  [4];
    int mdl_data [4];
    int mdl_last [4];

    logic [3:0] acc;
    logic [3:0] pend;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            mdl_val[j]  = 0;
            mdl_src[j]  = 0;
            mdl_data[j] = 0;
            mdl_last[j] = 3;    // so source 0 is first in line
        end
    endtask

    // One clock cycle: check the DUT against the model just before the
    // edge, then advance the model across the edge. acc returns which
    // sources the model says were accepted.
    task automatic cycle(output logic [3:0] acc_o);
        int         nval [4];
        int         nsrc [4];
        int         ndata[4];
        int         nlast[4];
        int         best;
        int         bestd;
        int         d;
        logic [3:0] exp_rdy;
        logic [3:0] exp_val;
        @(negedge clk);
        exp_rdy = '0;
        exp_val = '0;
        for (int j = 0; j < 4; j++) begin
            nval[j]  = mdl_val[j];
            nsrc[j]  = mdl_src[j];
            ndata[j] = mdl_data[j];
            nlast[j] = mdl_last[j];
            exp_val[j] = (mdl_val[j] != 0);
            // Winner: the requester coming soonest after the last served one.
            best  = -1;
            bestd = 4;
            for (int i = 0; i < 4; i++) begin
                if (s_val[i] && (int'(s_dst[i*2 +: 2]) == j)) begin
                    d = (i - mdl_last[j] - 1 + 8) % 4;
                    if (d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
            end
            if (best >= 0 && (mdl_val[j] == 0 || m_rdy[j])) begin
                exp_rdy[best] = 1'b1;
                nval[j]  = 1;
                nsrc[j]  = best;
                ndata[j] = int'(s_data[best*8 +: 8]);
                nlast[j] = best;
            end else if (mdl_val[j] != 0 && m_rdy[j]) begin
                nval[j] = 0;
            end
        end
        check_eq("s_rdy", 32'(s_rdy), 32'(exp_rdy));
        check_eq("m_val", 32'(m_val), 32'(exp_val));
        for (int j = 0; j < 4; j++) begin
            if (mdl_val[j] != 0) begin
                check_eq($sformatf("m_src%0d", j), 32'(m_src[j*2 +: 2]), 32'(mdl_src[j]));
                check_eq($sformatf("m_data%0d", j), 32'(m_data[j*8 +: 8]), 32'(mdl_data[j]));
            end
        end
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            mdl_val[j]  = nval[j];
            mdl_src[j]  = nsrc[j];
            mdl_data[j] = ndata[j];
            mdl_last[j] = nlast[j];
        end
        #1;
        acc_o = exp_rdy;
    endtask

    initial begin
        rst_n   = 1'b1;
        s_val   = '0; s_dst  = '0; s_data  = '0; m_rdy  = 4'hF;
        s_val3  = '0; s_dst3 = '0; s_data3 = '0; m_rdy3 = 3'h7;
        model_reset();

        // Reset values
        #2 rst_n = 1'b0;
        #10;
        check_eq("rst_m_val",   32'(m_val),   32'h0);
        check_eq("rst_m_src",   32'(m_src),   32'h0);
        check_eq("rst_m_data",  32'(m_data),  32'h0);
        check_eq("rst_s_rdy",   32'(s_rdy),   32'h0);
        check_eq("rst_dst_err", 32'(dst_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Parallel paths: s0->d2 0xA5, s1->d0 0x3C
        s_val  = 4'b0011;
        s_dst  = {2'd0, 2'd0, 2'd0, 2'd2};
        s_data = {8'h00, 8'h00, 8'h3C, 8'hA5};
        cycle(acc);
        check_eq("par_m_val", 32'(m_val),          32'h5);
        check_eq("par_data2", 32'(m_data[23:16]),  32'hA5);
        check_eq("par_src2",  32'(m_src[5:4]),     32'h0);
        check_eq("par_data0", 32'(m_data[7:0]),    32'h3C);
        check_eq("par_src0",  32'(m_src[1:0]),     32'h1);
        s_val = '0;
        cycle(acc);

        // Round robin: every source streams to d1
        s_val  = 4'hF;
        s_dst  = 8'b01_01_01_01;
        s_data = {8'h30, 8'h20, 8'h10, 8'h00};
        for (int k = 0; k < 8; k++) begin
            cycle(acc);
            check_eq("rr_src", 32'(m_src[3:2]), 32'(k % 4));
            check_eq("rr_val", 32'(m_val[1]),   32'h1);
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) s_data[i*8 +: 8] = s_data[i*8 +: 8] + 8'd1;
            end
        end
        s_val = '0;
        cycle(acc);

        // Backpressure on d3 with s2 pending
        m_rdy  = 4'b0111;
        s_val  = 4'b0100;
        s_dst  = 8'b00_11_00_00;
        s_data = 32'h0011_0000;
        cycle(acc);
        check_eq("bp_first", 32'(m_data[31:24]), 32'h11);
        s_data[23:16] = 8'h22;
        for (int k = 0; k < 5; k++) begin
            cycle(acc);
            check_eq("bp_s_rdy", 32'(s_rdy[2]),       32'h0);
            check_eq("bp_hold",  32'(m_data[31:24]),  32'h11);
            check_eq("bp_val",   32'(m_val[3]),       32'h1);
        end
        m_rdy = 4'hF;
        cycle(acc);
        check_eq("bp_repl",     32'(m_data[31:24]), 32'h22);
        check_eq("bp_repl_val", 32'(m_val[3]),      32'h1);
        s_val = '0;
        cycle(acc);

        // Out-of-range destination on the 4x3 instance
        s_val3  = 4'b0011;
        s_dst3  = {2'd0, 2'd0, 2'd3, 2'd0};
        s_data3 = 32'h0000_6655;
        #1;
        check_eq("oor_s_rdy", 32'(s_rdy3),   32'h1);
        check_eq("oor_pre",   32'(dst_err3), 32'h0);
        @(posedge clk);
        #1;
        check_eq("oor_err",   32'(dst_err3),     32'h1);
        check_eq("oor_m_val", 32'(m_val3),       32'h1);
        check_eq("oor_data",  32'(m_data3[7:0]), 32'h55);
        s_val3 = 4'b0010;
        #1;
        check_eq("oor_s_rdy1", 32'(s_rdy3), 32'h0);
        @(posedge clk);
        #1;
        s_val3 = '0;
        @(posedge clk);
        #1;
        check_eq("oor_sticky", 32'(dst_err3), 32'h1);
        check_eq("oor_main",   32'(dst_err),  32'h0);

        // Reset mid-traffic
        m_rdy  = 4'h0;
        s_val  = 4'b0011;
        s_dst  = 8'b00_00_01_00;
        s_data = 32'h0000_7766;
        cycle(acc);
        check_eq("pre_rst_m_val", 32'(m_val), 32'h3);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_m_val",  32'(m_val),    32'h0);
        check_eq("mid_rst_s_rdy",  32'(s_rdy),    32'h0);
        check_eq("mid_rst_err3",   32'(dst_err3), 32'h0);
        check_eq("mid_rst_m_data", 32'(m_data),   32'h0);
        model_reset();
        s_val = 4'hF;
        s_dst = 8'h00;
        m_rdy = 4'hF;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_eq("post_rst_grant", 32'(s_rdy), 32'h1);
        for (int k = 0; k < 4; k++) cycle(acc);
        s_val = '0;
        cycle(acc);

        // Random soak
        pend = '0;
        acc  = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && acc[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(2) != 0) begin
                    pend[i] = 1'b1;
                    s_dst[i*2 +: 2]  = 2'($urandom_range(3));
                    s_data[i*8 +: 8] = 8'($urandom_range(255));
                end
            end
            s_val = pend;
            m_rdy = 4'($urandom) | 4'($urandom);
            cycle(acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
